// File: rtl/partial_product_24x12.sv
// Sequential 24x12 shift-add partial-product generator: forms x = a*b[11:0] and
// y = a*b[23:12] over 12 steps for the 24x24 multiplier's combining adder.
module partial_product_24x12 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] x,
  output logic [35:0] y,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [35:0] mcand_q, mcand_d;
  logic [11:0] blo_q, blo_d;
  logic [11:0] bhi_q, bhi_d;
  logic [35:0] accx_q, accx_d;
  logic [35:0] accy_q, accy_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      blo_q   <= '0;
      bhi_q   <= '0;
      accx_q  <= '0;
      accy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      blo_q   <= blo_d;
      bhi_q   <= bhi_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Both slices share one shifted multiplicand; each slice adds it when its
  // current low multiplier bit is set.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    blo_d   = blo_q;
    bhi_d   = bhi_q;
    accx_d  = accx_q;
    accy_d  = accy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = {12'b0, a};
          blo_d   = b[11:0];
          bhi_d   = b[23:12];
          accx_d  = '0;
          accy_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        accx_d  = accx_q + (blo_q[0] ? mcand_q : 36'd0);
        accy_d  = accy_q + (bhi_q[0] ? mcand_q : 36'd0);
        mcand_d = mcand_q << 1;
        blo_d   = blo_q >> 1;
        bhi_d   = bhi_q >> 1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign x         = accx_q;
  assign y         = accy_q;

endmodule

// File: tb/tb_partial_product_24x12.sv
// Scoreboard bench for partial_product_24x12: expected slices are queued at
// accept time and compared whenever the DUT presents a result.
module tb_partial_product_24x12;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] x;
  logic [35:0] y;
  logic        busy;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [35:0] x;
    logic [35:0] y;
    int          acceptEdge;
  } exp_t;

  exp_t sb[$];
  int   errCount   = 0;
  int   checkCount = 0;
  int   cycleCnt   = 0;
  bit   seenFront  = 0;

  partial_product_24x12 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present operands, wait for the block to take them and queue the model result.
  task automatic applyStimulus(input logic [23:0] aVal, input logic [23:0] bVal,
                               input bit keepValid, output int edgeNo);
    int   waitCnt;
    exp_t e;
    waitCnt  = 0;
    edgeNo   = -1;
    in_valid = 1'b1;
    a        = aVal;
    b        = bVal;
    while (!in_ready && waitCnt < 200) begin
      tick();
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
    end else begin
      e.a          = aVal;
      e.b          = bVal;
      e.x          = {12'b0, aVal} * {24'b0, bVal[11:0]};
      e.y          = {12'b0, aVal} * {24'b0, bVal[23:12]};
      e.acceptEdge = cycleCnt + 1;
      edgeNo       = e.acceptEdge;
      sb.push_back(e);
      tick();
      if (!keepValid) in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int waitCnt;
    waitCnt = 0;
    while (sb.size() != 0 && waitCnt < 400) begin
      tick();
      waitCnt++;
    end
    checkOutput("drainTimeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    in_valid = 1'($urandom());
    a        = 24'($urandom());
    b        = 24'($urandom());
    rst_n    = 1'b0;
    #1;
    checkOutput("rst_inReady", 64'(in_ready), 64'd1);
    checkOutput("rst_outValid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_x", 64'(x), 64'd0);
    checkOutput("rst_y", 64'(y), 64'd0);
    sb.delete();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Output monitor: every cycle with a result presented is checked against
  // the queue head, including the hold cycles under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      seenFront = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousValid", 64'(out_valid), 64'd0);
      end else begin
        checkOutput("x", 64'(x), 64'(sb[0].x));
        checkOutput("y", 64'(y), 64'(sb[0].y));
        checkOutput("inReadyWhileDone", 64'(in_ready), 64'd0);
        checkOutput("busyWhileDone", 64'(busy), 64'd1);
        if (!seenFront) begin
          checkOutput("latency", 64'(cycleCnt - sb[0].acceptEdge), 64'd12);
          checkOutput("product", 64'({12'b0, x} + ({12'b0, y} << 12)),
                      64'({24'b0, sb[0].a} * {24'b0, sb[0].b}));
          seenFront = 1;
        end
        if (out_ready) begin
          void'(sb.pop_front());
          seenFront = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edgeNo;
    int prevEdge;
    int waitCnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1;
    checkOutput("init_inReady", 64'(in_ready), 64'd1);
    checkOutput("init_busy", 64'(busy), 64'd0);
    checkOutput("init_x", 64'(x), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] max operands and slice isolation");
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 0, edgeNo);
    waitDrain();
    applyStimulus(24'h123456, 24'h000001, 0, edgeNo);
    waitDrain();
    applyStimulus(24'h123456, 24'h001000, 0, edgeNo);
    waitDrain();
    applyStimulus(24'h000000, 24'hABCDEF, 0, edgeNo);
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(24'h000ABC, 24'h00F00F, 0, edgeNo);
    waitCnt = 0;
    while (!out_valid && waitCnt < 40) begin
      tick();
      waitCnt++;
    end
    checkOutput("bp_reachedDone", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    a        = 24'h000111;
    b        = 24'h000222;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_holdValid", 64'(out_valid), 64'd1);
      checkOutput("bp_inReady", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_turnaroundIdle", 64'(busy), 64'd0);
    checkOutput("bp_turnaroundReady", 64'(in_ready), 64'd1);
    applyStimulus(24'h000111, 24'h000222, 0, edgeNo);
    waitDrain();

    $display("[TB] reset mid-run");
    applyStimulus(24'h000123, 24'h000456, 0, edgeNo);
    for (int i = 0; i < 4; i++) tick();
    doReset();
    for (int i = 0; i < 16; i++) begin
      checkOutput("abort_noValid", 64'(out_valid), 64'd0);
      tick();
    end
    applyStimulus(24'h000002, 24'h003003, 0, edgeNo);
    waitDrain();

    $display("[TB] streaming");
    out_ready = 1'b1;
    prevEdge  = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(24'($urandom()), 24'($urandom()), 1, edgeNo);
      if (prevEdge >= 0) begin
        checkOutput("stream_interval", 64'(edgeNo - prevEdge), 64'd14);
      end
      prevEdge = edgeNo;
    end
    in_valid = 1'b0;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
